// File: rtl/uart_defs.sv
// Shared UART types: receiver state encoding, status flags and divider floor.
package uart_defs;

  localparam int MIN_DIVIDER = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } RXState_t;

  typedef struct packed {
    logic overrun_error;
    logic framing_error;
    logic parity_error;
  } RXStatus_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: loads a full or half period (divider clamped to
// MIN_DIVIDER), counts down to zero and holds there.
module uart_baud_cnt
  import uart_defs::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             half_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             zero_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] reload;

  assign eff_div = (divider_i < DIV_W'(MIN_DIVIDER)) ? DIV_W'(MIN_DIVIDER) : divider_i;
  assign reload  = half_i ? ((eff_div >> 1) - DIV_W'(1)) : (eff_div - DIV_W'(1));
  assign zero_o  = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = reload;
    end else if (!zero_o) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx, validates the start bit, samples
// data/parity/stop mid-bit and hands each word to the FIFO over valid/ready.
//
// state     | meaning
// RX_IDLE   | waiting for a start edge, or validating one (pending_q)
// RX_SHIFT  | sampling DATA_W data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the stop bit, then delivering the word
module uart_rx_core
  import uart_defs::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic [DIV_W-1:0]  divider,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              flush,
  input  logic              rx,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              parity_error_o,
  output logic              framing_error_o,
  output logic              overrun_error_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q, fell;

  RXState_t          state_q, state_d;
  logic              pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_err_q, par_err_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  RXStatus_t         status_q, status_d;

  logic cnt_load, cnt_half, cnt_zero;

  // Reset to ones so the line reads idle while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fell = rxs_prev_q & ~rxs;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .half_i    (cnt_half),
    .divider_i (divider),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    armed_d   = armed_q | rxs;
    data_d    = data_q;
    valid_d   = valid_q;
    status_d  = '0;
    cnt_load  = 1'b0;
    cnt_half  = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        if (pending_q) begin
          if (cnt_zero) begin
            pending_d = 1'b0;
            if (!rxs) begin
              state_d   = RX_SHIFT;
              cnt_load  = 1'b1;
              idx_d     = '0;
              par_err_d = 1'b0;
            end
          end
        end else if (rx_en && armed_q && fell) begin
          pending_d = 1'b1;
          cnt_load  = 1'b1;
          cnt_half  = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (cnt_zero) begin
          shift_d  = {rxs, shift_q[DATA_W-1:1]};
          idx_d    = idx_q + IDX_W'(1);
          cnt_load = 1'b1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = parity_en ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (cnt_zero) begin
          par_err_d = (^shift_q) ^ rxs ^ parity_odd;
          cnt_load  = 1'b1;
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_zero) begin
          state_d = RX_IDLE;
          if (!rxs) begin
            armed_d = 1'b0;
          end
          // A word still waiting is only overrun if it is not being taken now.
          if (!valid_q || ready_i) begin
            data_d                 = shift_q;
            valid_d                = 1'b1;
            status_d.parity_error  = par_err_q;
            status_d.framing_error = ~rxs;
          end else begin
            status_d.overrun_error = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (flush || !rx_en) begin
      state_d   = RX_IDLE;
      pending_d = 1'b0;
      valid_d   = 1'b0;
      data_d    = data_q;
      status_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      status_q  <= status_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign parity_error_o  = status_q.parity_error;
  assign framing_error_o = status_q.framing_error;
  assign overrun_error_o = status_q.overrun_error;
  assign busy_o          = (state_q != RX_IDLE) || pending_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames built from the bit-level
// frame format, deliveries compared against expected words, timing and flags.
module tb_uart_rx_core;

  localparam int DW  = 8;
  localparam int DVW = 16;
  localparam int SS  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx_en = 1'b0;
  logic [DVW-1:0] divider = 16'd16;
  logic           parity_en = 1'b0;
  logic           parity_odd = 1'b0;
  logic           flush = 1'b0;
  logic           rx = 1'b1;
  logic           ready_i = 1'b0;
  logic [DW-1:0]  data_o;
  logic           valid_o, parity_error_o, framing_error_o, overrun_error_o, busy_o;

  uart_rx_core #(.DATA_W(DW), .DIV_W(DVW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .divider(divider),
    .parity_en(parity_en), .parity_odd(parity_odd), .flush(flush), .rx(rx),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .parity_error_o(parity_error_o), .framing_error_o(framing_error_o),
    .overrun_error_o(overrun_error_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Delivery monitor: a word is new unless last cycle held an untaken word.
  logic [DW-1:0] q_data[$];
  int            q_cyc[$];
  bit            q_pe[$];
  bit            q_fe[$];
  int            pe_cnt, fe_cnt, oe_cnt;
  bit            pv, pr;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (valid_o && !(pv && !pr)) begin
        q_data.push_back(data_o);
        q_cyc.push_back(cyc);
        q_pe.push_back(parity_error_o);
        q_fe.push_back(framing_error_o);
      end
      if (parity_error_o)  pe_cnt++;
      if (framing_error_o) fe_cnt++;
      if (overrun_error_o) oe_cnt++;
      pv = valid_o;
      pr = ready_i;
    end
  end

  function automatic int eff_div(int d);
    return (d < 4) ? 4 : d;
  endfunction

  // Cycle (edge count) at which valid_o is first seen for a frame started at c.
  function automatic int exp_valid_cyc(int c, int n, bit pen);
    return c + SS + 1 + n / 2 + (DW + 1 + int'(pen)) * n;
  endfunction

  task automatic clear_mon();
    q_data.delete(); q_cyc.delete(); q_pe.delete(); q_fe.delete();
    pe_cnt = 0; fe_cnt = 0; oe_cnt = 0;
  endtask

  // Drives up to nbits bits of a frame; c is the edge count when the start bit began.
  task automatic drive_frame(input logic [DW-1:0] d, input bit pbit, input bit stopb,
                             input int nbits, output int c);
    logic b[0:11];
    int   total;
    int   n;
    n = eff_div(int'(divider));
    b[0] = 1'b0;
    for (int k = 0; k < DW; k++) b[1+k] = d[k];
    total = DW + 1;
    if (parity_en) begin b[total] = pbit; total++; end
    b[total] = stopb;
    total++;
    @(posedge clk); #1;
    c = cyc;
    for (int i = 0; i < total && i < nbits; i++) begin
      rx = b[i];
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input int want, output bit ok);
    int k;
    k = 0;
    while (q_data.size() < want && k < 400) begin
      @(negedge clk);
      k++;
    end
    ok = (q_data.size() >= want);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_en = 1'b1; rx = 1'b0; ready_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_o !== 8'h00 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: data=%h valid=%b expected data=00 valid=0", data_o, valid_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", busy_o);
    end
    checks++;
    if ({parity_error_o, framing_error_o, overrun_error_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_err: got %b%b%b expected 000", parity_error_o, framing_error_o, overrun_error_o);
    end
    rx = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int c; bit ok;
    clear_mon();
    divider = 16; parity_en = 1'b0; ready_i = 1'b1;
    drive_frame(8'hA5, 1'b0, 1'b1, 99, c);
    wait_q(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got 0 words expected 1"); end
    else begin
      checks++;
      if (q_data[0] !== 8'hA5) begin
        failures++; $display("FAIL basic_data: got %h expected a5", q_data[0]);
      end
      checks++;
      if (q_cyc[0] != exp_valid_cyc(c, 16, 1'b0)) begin
        failures++;
        $display("FAIL basic_latency: got cycle %0d expected %0d", q_cyc[0], exp_valid_cyc(c, 16, 1'b0));
      end
      checks++;
      if (pe_cnt + fe_cnt + oe_cnt != 0) begin
        failures++; $display("FAIL basic_err: got pe=%0d fe=%0d oe=%0d expected 0", pe_cnt, fe_cnt, oe_cnt);
      end
    end
  endtask

  task automatic test_parity();
    int c; bit ok;
    logic [DW-1:0] dd[3] = '{8'h07, 8'h07, 8'h07};
    bit            pb[3] = '{1'b1, 1'b0, 1'b0};
    bit            od[3] = '{1'b0, 1'b0, 1'b1};
    bit            ep[3] = '{1'b0, 1'b1, 1'b0};
    clear_mon();
    divider = 16; parity_en = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      parity_odd = od[i];
      drive_frame(dd[i], pb[i], 1'b1, 99, c);
    end
    wait_q(3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL parity_timeout: got %0d words expected 3", q_data.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_data[i] !== dd[i] || q_pe[i] !== ep[i]) begin
          failures++;
          $display("FAIL parity_%0d: got data=%h pe=%b expected data=%h pe=%b", i, q_data[i], q_pe[i], dd[i], ep[i]);
        end
      end
    end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c, n, n_ok; bit ok, perr;
    logic [DW-1:0] e_data[$];
    int            e_cyc[$];
    bit            e_pe[$];
    logic [DW-1:0] d;
    clear_mon();
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      divider    = DVW'($urandom_range(2, 12));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      perr       = 1'($urandom_range(0, 1));
      d          = DW'($urandom_range(0, 255));
      n = eff_div(int'(divider));
      drive_frame(d, (^d) ^ parity_odd ^ perr, 1'b1, 99, c);
      e_data.push_back(d);
      e_cyc.push_back(exp_valid_cyc(c, n, parity_en));
      e_pe.push_back(parity_en & perr);
    end
    wait_q(10, ok);
    checks++;
    if (!ok || q_data.size() != 10) begin
      failures++; $display("FAIL b2b_count: got %0d words expected 10", q_data.size());
    end else begin
      n_ok = 0;
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (q_data[i] !== e_data[i] || q_cyc[i] != e_cyc[i] || q_pe[i] !== e_pe[i] || q_fe[i] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_%0d: got data=%h cyc=%0d pe=%b fe=%b expected data=%h cyc=%0d pe=%b fe=0",
                   i, q_data[i], q_cyc[i], q_pe[i], q_fe[i], e_data[i], e_cyc[i], e_pe[i]);
        end else n_ok++;
      end
    end
    checks++;
    if (oe_cnt != 0 || fe_cnt != 0) begin
      failures++; $display("FAIL b2b_err: got oe=%0d fe=%0d expected 0", oe_cnt, fe_cnt);
    end
    divider = 16; parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_framing();
    int c, busy_seen; bit ok;
    clear_mon();
    divider = 16; ready_i = 1'b1;
    drive_frame(8'h3C, 1'b0, 1'b0, 99, c);
    busy_seen = 0;
    repeat (40 * 16) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
    end
    checks++;
    if (fe_cnt != 1 || q_data.size() != 1) begin
      failures++; $display("FAIL frame_pulse: got fe=%0d words=%0d expected fe=1 words=1", fe_cnt, q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'h3C || q_fe[0] !== 1'b1) begin
        failures++; $display("FAIL frame_word: got data=%h fe=%b expected data=3c fe=1", q_data[0], q_fe[0]);
      end
    end
    checks++;
    if (busy_seen != 0) begin
      failures++; $display("FAIL frame_break_busy: got %0d busy cycles expected 0", busy_seen);
    end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    drive_frame(8'h81, 1'b0, 1'b1, 99, c);
    wait_q(2, ok);
    checks++;
    if (!ok || q_data[1] !== 8'h81 || fe_cnt != 1) begin
      failures++;
      $display("FAIL frame_recover: got words=%0d fe=%0d expected words=2 data=81 fe=1", q_data.size(), fe_cnt);
    end
  endtask

  task automatic test_glitch();
    int c;
    clear_mon();
    divider = 16;
    @(posedge clk); #1;
    c = cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    while (cyc < c + 4) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise: got %b expected 1", busy_o); end
    repeat (40) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || q_data.size() != 0 || pe_cnt + fe_cnt + oe_cnt != 0) begin
      failures++;
      $display("FAIL glitch_quiet: got busy=%b words=%0d errs=%0d expected 0/0/0",
               busy_o, q_data.size(), pe_cnt + fe_cnt + oe_cnt);
    end
  endtask

  task automatic test_overrun();
    int c, cst; bit ok;
    clear_mon();
    divider = 16; ready_i = 1'b0;
    drive_frame(8'h11, 1'b0, 1'b1, 99, c);
    drive_frame(8'h22, 1'b0, 1'b1, 99, c);
    repeat (4) @(negedge clk);
    checks++;
    if (data_o !== 8'h11 || valid_o !== 1'b1 || oe_cnt != 1 || q_data.size() != 1) begin
      failures++;
      $display("FAIL overrun_hold: got data=%h valid=%b oe=%0d words=%0d expected 11/1/1/1",
               data_o, valid_o, oe_cnt, q_data.size());
    end
    // Take the held word in exactly the cycle the next word lands.
    fork
      drive_frame(8'h44, 1'b0, 1'b1, 99, c);
      begin
        @(posedge clk); #1;
        cst = cyc;
        while (cyc < exp_valid_cyc(cst, 16, 1'b0) - 1) begin @(posedge clk); #1; end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
      end
    join
    @(negedge clk);
    checks++;
    if (data_o !== 8'h44 || valid_o !== 1'b1 || oe_cnt != 1) begin
      failures++;
      $display("FAIL overrun_simul: got data=%h valid=%b oe=%0d expected 44/1/1", data_o, valid_o, oe_cnt);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL overrun_take: got valid=%b expected 0", valid_o); end
    drive_frame(8'h33, 1'b0, 1'b1, 99, c);
    wait_q(3, ok);
    checks++;
    if (!ok || q_data[2] !== 8'h33 || oe_cnt != 1) begin
      failures++;
      $display("FAIL overrun_next: got words=%0d oe=%0d expected 3 words last=33 oe=1", q_data.size(), oe_cnt);
    end
  endtask

  task automatic test_flush();
    int c; bit ok;
    clear_mon();
    divider = 16; ready_i = 1'b0;
    drive_frame(8'h66, 1'b0, 1'b1, 99, c);
    drive_frame(8'h99, 1'b0, 1'b1, 5, c);
    checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b1) begin
      failures++; $display("FAIL flush_pre: got busy=%b valid=%b expected 1/1", busy_o, valid_o);
    end
    flush = 1'b1; rx = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle: got busy=%b valid=%b expected 0/0", busy_o, valid_o);
    end
    repeat (48) @(negedge clk);
    checks++;
    if (pe_cnt + fe_cnt + oe_cnt != 0 || q_data.size() != 1) begin
      failures++;
      $display("FAIL flush_quiet: got errs=%0d words=%0d expected 0/1", pe_cnt + fe_cnt + oe_cnt, q_data.size());
    end
    ready_i = 1'b1;
    drive_frame(8'h5A, 1'b0, 1'b1, 99, c);
    wait_q(2, ok);
    checks++;
    if (!ok || q_data[1] !== 8'h5A || q_pe[1] || q_fe[1]) begin
      failures++; $display("FAIL flush_next: got words=%0d expected 2 words last=5a clean", q_data.size());
    end
    clear_mon();
    drive_frame(8'hF0, 1'b0, 1'b1, 5, c);
    rst_n = 1'b0; rx = 1'b1;
    #2;
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: got busy=%b valid=%b data=%h expected 0/0/00", busy_o, valid_o, data_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    drive_frame(8'h5A, 1'b0, 1'b1, 99, c);
    wait_q(1, ok);
    checks++;
    if (!ok || q_data[0] !== 8'h5A || q_cyc[0] != exp_valid_cyc(c, 16, 1'b0) || pe_cnt + fe_cnt + oe_cnt != 0) begin
      failures++; $display("FAIL rst_next: got words=%0d expected 1 word 5a on time, no errors", q_data.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_overrun();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
